// File: rtl/hyper_cfg_regs_pkg.sv
// rtl/hyper_cfg_regs_pkg.sv - shared constants and types for the Hyperbus configuration window
package hyper_cfg_regs_pkg;

    localparam logic [7:0] OFF_LATENCY   = 8'h00;
    localparam logic [7:0] OFF_CS_MAX    = 8'h04;
    localparam logic [7:0] OFF_CHIP_EN   = 8'h08;
    localparam logic [7:0] OFF_RST_CTRL  = 8'h0C;
    localparam logic [7:0] OFF_RST_PULSE = 8'h10;
    localparam logic [7:0] OFF_RST_WAIT  = 8'h14;

    localparam logic [3:0]  RST_VAL_LATENCY = 4'd6;
    localparam logic [15:0] RST_VAL_CS_MAX  = 16'd666;
    localparam logic [15:0] RST_VAL_PULSE   = 16'd200;
    localparam logic [15:0] RST_VAL_WAIT    = 16'd300;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT
    } hyp_rst_state_e;

    typedef enum logic {
        REQ_IDLE,
        REQ_RESP
    } req_state_e;

    typedef struct packed {
        logic [47:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } cheshire_reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } cheshire_reg_rsp_t;

    function automatic logic [31:0] strb_mask(logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/hyper_rst_seq.sv
// rtl/hyper_rst_seq.sv - Hyperbus device-reset sequencer: pulse phase then wait phase
module hyper_rst_seq
    import hyper_cfg_regs_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start,
    input  logic [15:0] pulse_cnt,
    input  logic [15:0] wait_cnt,
    output logic        hyp_rst_o,
    output logic        busy_o
);

    hyp_rst_state_e state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [15:0]    wait_q, wait_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            wait_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
        end
    end

    // Both counts are captured at start so register writes mid-sequence only affect the next run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PULSE;
                    cnt_d   = (pulse_cnt == 16'd0) ? 16'd1 : pulse_cnt;
                    wait_d  = wait_cnt;
                end
            end
            S_PULSE: begin
                if (cnt_q <= 16'd1) begin
                    if (wait_q == 16'd0) begin
                        state_d = S_IDLE;
                        cnt_d   = 16'd0;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = wait_q;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 16'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    assign hyp_rst_o = (state_q == S_PULSE);
    assign busy_o    = (state_q != S_IDLE);

endmodule

// File: rtl/hyper_cfg_regs.sv
// rtl/hyper_cfg_regs.sv - register-bus responder holding Hyperbus PHY config and reset sequencer control
module hyper_cfg_regs
    import hyper_cfg_regs_pkg::*;
#(
    parameter int unsigned NumChips = 2,
    parameter type reg_req_t = hyper_cfg_regs_pkg::cheshire_reg_req_t,
    parameter type reg_rsp_t = hyper_cfg_regs_pkg::cheshire_reg_rsp_t
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  reg_req_t            reg_req_i,
    output reg_rsp_t            reg_rsp_o,
    output logic [3:0]          cfg_latency_o,
    output logic [15:0]         cfg_cs_max_o,
    output logic [NumChips-1:0] cfg_chip_en_o,
    output logic                hyp_rst_o,
    output logic                busy_o
);

    req_state_e          req_q, req_d;
    logic [3:0]          latency_q;
    logic [15:0]         cs_max_q;
    logic [NumChips-1:0] chip_en_q;
    logic [15:0]         pulse_q;
    logic [15:0]         wait_q;
    logic [31:0]         rdata_q, rdata_d;
    logic                error_q, error_d;

    logic [5:0]  word;
    logic [31:0] wmask;
    logic [31:0] wdata;
    logic        accept;
    logic        wr_en;
    logic        seq_start;
    logic        busy;
    logic        unused_bits;

    assign word   = reg_req_i.addr[7:2];
    assign wdata  = reg_req_i.wdata;
    assign wmask  = strb_mask(reg_req_i.wstrb);
    assign accept = (req_q == REQ_IDLE) && reg_req_i.valid;
    assign unused_bits = ^{reg_req_i.addr[47:8], reg_req_i.addr[1:0], wdata[31:16], wmask[31:16]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q <= REQ_IDLE;
        end else begin
            req_q <= req_d;
        end
    end

    always_comb begin
        req_d = req_q;
        case (req_q)
            REQ_IDLE: if (reg_req_i.valid) req_d = REQ_RESP;
            REQ_RESP: req_d = REQ_IDLE;
            default:  req_d = REQ_IDLE;
        endcase
    end

    // Read mux; unmapped offsets flag an error and suppress any write.
    always_comb begin
        rdata_d = 32'd0;
        error_d = 1'b0;
        case (word)
            OFF_LATENCY[7:2]:   rdata_d = {28'd0, latency_q};
            OFF_CS_MAX[7:2]:    rdata_d = {16'd0, cs_max_q};
            OFF_CHIP_EN[7:2]:   rdata_d = 32'(chip_en_q);
            OFF_RST_CTRL[7:2]:  rdata_d = {31'd0, busy};
            OFF_RST_PULSE[7:2]: rdata_d = {16'd0, pulse_q};
            OFF_RST_WAIT[7:2]:  rdata_d = {16'd0, wait_q};
            default:            error_d = 1'b1;
        endcase
    end

    assign wr_en     = accept && reg_req_i.write && !error_d;
    assign seq_start = wr_en && (word == OFF_RST_CTRL[7:2]) && reg_req_i.wstrb[0] && wdata[0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            latency_q <= RST_VAL_LATENCY;
            cs_max_q  <= RST_VAL_CS_MAX;
            chip_en_q <= {NumChips{1'b1}};
            pulse_q   <= RST_VAL_PULSE;
            wait_q    <= RST_VAL_WAIT;
        end else if (wr_en) begin
            case (word)
                OFF_LATENCY[7:2]:
                    latency_q <= (latency_q & ~wmask[3:0]) | (wdata[3:0] & wmask[3:0]);
                OFF_CS_MAX[7:2]:
                    cs_max_q <= (cs_max_q & ~wmask[15:0]) | (wdata[15:0] & wmask[15:0]);
                OFF_CHIP_EN[7:2]:
                    chip_en_q <= (chip_en_q & ~wmask[NumChips-1:0])
                               | (wdata[NumChips-1:0] & wmask[NumChips-1:0]);
                OFF_RST_PULSE[7:2]:
                    pulse_q <= (pulse_q & ~wmask[15:0]) | (wdata[15:0] & wmask[15:0]);
                OFF_RST_WAIT[7:2]:
                    wait_q <= (wait_q & ~wmask[15:0]) | (wdata[15:0] & wmask[15:0]);
                default: ;
            endcase
        end
    end

    // Response data is held only for the single ready cycle, otherwise zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= 32'd0;
            error_q <= 1'b0;
        end else if (accept) begin
            rdata_q <= rdata_d;
            error_q <= error_d;
        end else if (req_q == REQ_RESP) begin
            rdata_q <= 32'd0;
            error_q <= 1'b0;
        end
    end

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.rdata = rdata_q;
        reg_rsp_o.error = error_q;
        reg_rsp_o.ready = (req_q == REQ_RESP);
    end

    hyper_rst_seq u_rst_seq (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start     (seq_start),
        .pulse_cnt (pulse_q),
        .wait_cnt  (wait_q),
        .hyp_rst_o (hyp_rst_o),
        .busy_o    (busy)
    );

    assign busy_o        = busy;
    assign cfg_latency_o = latency_q;
    assign cfg_cs_max_o  = cs_max_q;
    assign cfg_chip_en_o = chip_en_q;

endmodule
